// File: rtl/bias_sram_reader_if.sv
// Bundle of the bias reader's job-control, output stream and SRAM read-port
// signals. The reader drives through "master"; the environment uses "slave".
interface bias_sram_reader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 18
);
    // job control
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic              err;
    // bias stream to the PE array
    logic [DATA_W-1:0] bias_data;
    logic              bias_valid;
    logic              bias_ready;
    // single-port SRAM
    logic              mem_cs;
    logic              mem_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_W_req;
    logic [DATA_W-1:0] mem_W_data;
    logic [DATA_W-1:0] mem_R_data;

    modport master (
        input  start, base_addr, count, bias_ready, mem_R_data,
        output busy, done, err, bias_data, bias_valid,
               mem_cs, mem_oe, mem_addr, mem_W_req, mem_W_data
    );

    modport slave (
        output start, base_addr, count, bias_ready, mem_R_data,
        input  busy, done, err, bias_data, bias_valid,
               mem_cs, mem_oe, mem_addr, mem_W_req, mem_W_data
    );
endinterface

// File: rtl/bias_sram_reader.sv
// Read-side initiator for the bias SRAM. A start pulse launches a job that
// reads COUNT consecutive words from BASE_ADDR and streams them out on a
// valid/ready channel, with a small FIFO absorbing the 1-cycle SRAM latency
// and consumer backpressure.
module bias_sram_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 18,
    parameter int MEM_WORDS  = 196608,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    bias_sram_reader_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 2;
    localparam logic [ADDR_W:0]  MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [OCC_W-1:0] DEPTH_V   = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;

    logic [ADDR_W-1:0] addr_q;      // next word address to issue
    logic [CNT_W-1:0]  rem_q;       // reads still to issue
    logic              inflight;    // a read was issued last cycle; data returns now
    logic              err_q;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;

    logic              fifo_nempty;
    logic              push, pop;
    logic              issue, last_issue;
    logic              cnt_zero, range_bad;
    logic [ADDR_W:0]   job_end;
    logic [OCC_W-1:0]  occ_eff;
    logic              busy_c, done_c, cs_c;

    assign fifo_nempty = (fifo_cnt != '0);
    assign push        = inflight;
    assign pop         = fifo_nempty & bus.bias_ready;

    // base+count-1 > MEM_WORDS-1 is evaluated as base+count > MEM_WORDS one bit
    // wider than the address, so a huge base cannot wrap into a legal range.
    assign cnt_zero  = (bus.count == '0);
    assign job_end   = {1'b0, bus.base_addr} + (ADDR_W+1)'(bus.count);
    assign range_bad = (job_end > MEM_LIMIT);

    // Slots already claimed: buffered words plus the one returning now. A pop
    // in this same cycle frees its slot before the next issued word can land,
    // so it is credited here; that keeps one word per cycle flowing with a
    // 2-entry buffer while never letting occupancy exceed FIFO_DEPTH.
    assign occ_eff    = OCC_W'(fifo_cnt) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue      = (state == S_READ) && (occ_eff < DEPTH_V);
    assign last_issue = issue && (rem_q == CNT_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; DRAIN exits on the cycle the last word is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start)
                    state_nxt = (cnt_zero || range_bad) ? S_DONE : S_READ;
            end
            S_READ: begin
                if (last_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!inflight && (fifo_cnt == '0 ||
                                  (fifo_cnt == (PTR_W+1)'(1) && pop)))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        cs_c   = 1'b0;
        case (state)
            S_READ: begin
                busy_c = 1'b1;
                cs_c   = issue;
            end
            S_DRAIN: busy_c = 1'b1;
            S_DONE:  done_c = 1'b1;
            default: ;
        endcase
    end

    // Job capture, address/remaining-count stepping and read-latency tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (state == S_IDLE && bus.start) begin
                addr_q <= bus.base_addr;
                rem_q  <= bus.count;
                err_q  <= !cnt_zero && range_bad;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - CNT_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; reset drops anything buffered or returning
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // FIFO storage; the returned word is taken exactly in its data cycle
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.mem_R_data;
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.err        = err_q;
    assign bus.bias_valid = fifo_nempty;
    assign bus.bias_data  = fifo_mem[rd_ptr];
    assign bus.mem_cs     = cs_c;
    assign bus.mem_oe     = inflight;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_W_req  = 1'b1;
    assign bus.mem_W_data = '0;
endmodule

// File: tb/tb_bias_sram_reader.sv
// Directed bench for bias_sram_reader: SRAM model, ready pattern generator,
// stream/SRAM monitor and hand-computed expectations per job.
module tb_bias_sram_reader;
    localparam int MW = 196608;

    logic clk;
    logic rst;

    bias_sram_reader_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(18)) bus();

    bias_sram_reader #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(18), .MEM_WORDS(MW), .FIFO_DEPTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] sram [MW];
    logic [31:0] got_q [$];
    logic [31:0] cs_q  [$];
    int          done_cnt;
    int          cs_cnt;
    int          occ;
    bit          last_oe, last_pop;
    bit          mon_en;
    int          ready_mode;   // 0: low, 1: high, 2: pattern
    int          cyc;
    logic [31:0] rdy_pat;
    bit          pend_cs;
    logic [31:0] pend_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int a);
        logic [15:0] w;
        w = sram[a];
        return {{16{w[15]}}, w};
    endfunction

    // SRAM: request seen mid-cycle, data presented after the issue edge
    initial begin
        bus.mem_R_data = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            pend_cs   = (bus.mem_cs === 1'b1) && (bus.mem_addr < 32'(MW));
            pend_addr = bus.mem_addr;
            @(posedge clk);
            bus.mem_R_data <= pend_cs ? exp_word(int'(pend_addr)) : 32'hDEAD_BEEF;
        end
    end

    // Consumer ready: toggling stretches plus 5-cycle low holds in pattern mode
    initial begin
        rdy_pat        = 32'b1111_1100_0001_0101_1000_0010_1010_1011;
        cyc            = 0;
        bus.bias_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       bus.bias_ready = 1'b0;
                1:       bus.bias_ready = 1'b1;
                default: bus.bias_ready = rdy_pat[cyc % 32];
            endcase
        end
    end

    // Monitor: occupancy model from observed returns/accepts, captures words and issues
    initial begin : mon
        bit pop_now;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                occ      = 0;
                last_oe  = 1'b0;
                last_pop = 1'b0;
            end else begin
                occ     = occ + int'(last_oe) - int'(last_pop);
                pop_now = bus.bias_valid & bus.bias_ready;
                check("valid_vs_occ", bus.bias_valid, occ != 0);
                if (bus.mem_cs) begin
                    cs_cnt++;
                    cs_q.push_back(bus.mem_addr);
                    check("cs_gate", (occ + int'(bus.mem_oe) - int'(pop_now)) < 2, 1);
                    check("cs_busy", bus.busy, 1);
                    check("w_idle", {bus.mem_W_req, bus.mem_W_data}, {1'b1, 32'h0});
                end
                if (pop_now)  got_q.push_back(bus.bias_data);
                if (bus.done) done_cnt++;
                last_oe  = bus.mem_oe;
                last_pop = pop_now;
            end
        end
    end

    task automatic clear_job();
        got_q.delete();
        cs_q.delete();
        done_cnt = 0;
        cs_cnt   = 0;
    endtask

    task automatic drive_start(input int base, input int n);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = 32'(base);
        bus.count     = 18'(n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int base, input int n, input bit exp_err);
        int ne;
        for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge clk);
        check({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_err"}, bus.err, exp_err);
        check({tag, "_busy_off"}, bus.busy, 0);
        ne = exp_err ? 0 : n;
        check({tag, "_nwords"}, got_q.size(), ne);
        check({tag, "_nissue"}, cs_cnt, ne);
        for (int i = 0; i < ne; i++) begin
            if (i < got_q.size()) check({tag, "_data"}, got_q[i], exp_word(base + i));
            if (i < cs_q.size())  check({tag, "_addr"}, cs_q[i], 64'(base + i));
        end
    endtask

    initial begin : main
        logic [31:0] t2_exp [4];
        t2_exp = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_7FFF, 32'hFFFF_8000};

        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.count     = '0;
        mon_en        = 1'b0;
        ready_mode    = 1;
        for (int a = 0; a < MW; a++) sram[a] = 16'(a * 40503 + 7);
        sram[100] = 16'h0001;
        sram[101] = 16'hFFFF;
        sram[102] = 16'h7FFF;
        sram[103] = 16'h8000;

        // reset asserted between clock edges takes effect at once
        #13 rst = 1'b1;
        #1;
        check("rst_busy",   bus.busy,       0);
        check("rst_done",   bus.done,       0);
        check("rst_err",    bus.err,        0);
        check("rst_valid",  bus.bias_valid, 0);
        check("rst_cs",     bus.mem_cs,     0);
        check("rst_oe",     bus.mem_oe,     0);
        check("rst_addr",   bus.mem_addr,   0);
        check("rst_wreq",   bus.mem_W_req,  1);
        check("rst_wdata",  bus.mem_W_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // streaming, ready held high: 4 back-to-back words, done after last accept
        clear_job();
        drive_start(100, 4);
        @(negedge clk);
        check("s_a_cs",    bus.mem_cs,     1);
        check("s_a_addr",  bus.mem_addr,   100);
        check("s_a_busy",  bus.busy,       1);
        check("s_a_valid", bus.bias_valid, 0);
        @(negedge clk);
        check("s_b_cs",    bus.mem_cs,     1);
        check("s_b_addr",  bus.mem_addr,   101);
        check("s_b_oe",    bus.mem_oe,     1);
        check("s_b_valid", bus.bias_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s_valid", bus.bias_valid, 1);
            check("s_data",  bus.bias_data,  t2_exp[i]);
        end
        @(negedge clk);
        check("s_done",      bus.done,       1);
        check("s_done_busy", bus.busy,       0);
        check("s_end_valid", bus.bias_valid, 0);
        @(negedge clk);
        check("s_done_pulse", bus.done, 0);
        repeat (2) @(negedge clk);
        check("s_done_once", done_cnt,     1);
        check("s_nwords",    got_q.size(), 4);

        // backpressure
        ready_mode = 2;
        clear_job();
        drive_start(200, 8);
        finish_job("bp", 200, 8, 1'b0);
        ready_mode = 1;

        // empty job
        clear_job();
        drive_start(50, 0);
        @(negedge clk);
        check("c0_done", bus.done, 1);
        check("c0_busy", bus.busy, 0);
        check("c0_err",  bus.err,  0);
        finish_job("c0", 50, 0, 1'b0);

        // last legal window
        clear_job();
        drive_start(196600, 8);
        finish_job("top", 196600, 8, 1'b0);

        // one past the end: rejected
        clear_job();
        drive_start(196601, 8);
        @(negedge clk);
        check("rng_err",  bus.err,  1);
        check("rng_done", bus.done, 1);
        finish_job("rng", 196601, 8, 1'b1);

        // reset in the middle of a job
        ready_mode = 0;
        clear_job();
        drive_start(300, 6);
        repeat (2) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy",  bus.busy,       0);
        check("mid_rst_done",  bus.done,       0);
        check("mid_rst_valid", bus.bias_valid, 0);
        check("mid_rst_cs",    bus.mem_cs,     0);
        check("mid_rst_oe",    bus.mem_oe,     0);
        repeat (3) @(negedge clk);
        check("mid_no_done",  done_cnt,       0);
        check("mid_valid_lo", bus.bias_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 1;
        clear_job();
        drive_start(500, 3);
        finish_job("fresh", 500, 3, 1'b0);

        // start while busy is ignored
        clear_job();
        drive_start(600, 5);
        bus.start     = 1'b1;
        bus.base_addr = 32'd900;
        bus.count     = 18'd2;
        @(posedge clk);
        #1 bus.start = 1'b0;
        finish_job("ign", 600, 5, 1'b0);
        repeat (10) @(negedge clk);
        check("ign_done_once", done_cnt, 1);
        check("ign_nissue",    cs_cnt,   5);
        check("ign_idle",      bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
